// File: rtl/spi_multi_bank_loader_if.sv
// Signal bundle between a serial stream source and the multi-bank SRAM loader.
// The master drives framing, serial data and load setup; the slave returns write and status.
interface spi_multi_bank_loader_if #(
    parameter int NUM_CH    = 4,
    parameter int MEM_BW    = 18,
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int LW = $clog2(MEM_DEPTH + 1);

    logic                     sos;
    logic                     eos;
    logic [NUM_CH-1:0]        ser_in;
    logic [NUM_CH-1:0]        ch_en;
    logic [LW-1:0]            num_valid_lines;
    logic [NUM_CH-1:0]        wr_en;
    logic [AW-1:0]            wr_addr;
    logic [NUM_CH*MEM_BW-1:0] wr_data;
    logic                     busy;
    logic                     done;
    logic                     err_underrun;
    logic [1:0]               dbg_state;

    modport master (
        output sos, eos, ser_in, ch_en, num_valid_lines,
        input  wr_en, wr_addr, wr_data, busy, done, err_underrun, dbg_state
    );

    modport slave (
        input  sos, eos, ser_in, ch_en, num_valid_lines,
        output wr_en, wr_addr, wr_data, busy, done, err_underrun, dbg_state
    );
endinterface

// File: rtl/spi_multi_bank_loader.sv
// Deserialises NUM_CH lockstep serial streams into MEM_BW-bit words and writes them to
// per-channel SRAM ports at consecutive addresses, framed by sos/eos.
module spi_multi_bank_loader #(
    parameter int NUM_CH    = 4,
    parameter int MEM_BW    = 18,
    parameter int MEM_DEPTH = 256,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_multi_bank_loader_if.slave  bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int LW = $clog2(MEM_DEPTH + 1);
    localparam int BW = $clog2(MEM_BW);
    localparam logic [LW-1:0] DEPTH_L  = LW'(MEM_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(MEM_BW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [NUM_CH-1:0]             ch_en_q, ch_en_d;
    logic [LW-1:0]                 lines_q, lines_d;
    logic [LW-1:0]                 word_cnt_q, word_cnt_d;
    logic [BW-1:0]                 bit_cnt_q, bit_cnt_d;
    logic [NUM_CH-1:0][MEM_BW-1:0] shift_q, shift_d, shifted;
    logic [NUM_CH-1:0]             wr_en_q, wr_en_d;
    logic [AW-1:0]                 wr_addr_q, wr_addr_d;
    logic [NUM_CH*MEM_BW-1:0]      wr_data_q, wr_data_d;
    logic                          err_q, err_d;

    // Shift-register contents after absorbing this cycle's serial bit on every channel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (MSB_FIRST) begin
                shifted[c] = {shift_q[c][MEM_BW-2:0], bus.ser_in[c]};
            end else begin
                shifted[c] = {bus.ser_in[c], shift_q[c][MEM_BW-1:1]};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_en_d    = ch_en_q;
        lines_d    = lines_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.sos) begin
                    ch_en_d    = bus.ch_en;
                    lines_d    = (bus.num_valid_lines > DEPTH_L) ? DEPTH_L : bus.num_valid_lines;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = (lines_d == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                // One idle cycle after the final write so done follows the last strobe.
                if (word_cnt_q == lines_q) begin
                    state_d = S_DONE;
                end else begin
                    shift_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + 1'b1;
                        wr_en_d    = ch_en_q;
                        wr_addr_d  = word_cnt_q[AW-1:0];
                        wr_data_d  = shifted;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // A word finishing on the eos cycle is still written above.
                    if (bus.eos && (word_cnt_d != lines_q)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ch_en_q    <= '0;
            lines_q    <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_en_q    <= ch_en_d;
            lines_q    <= lines_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.busy         = (state_q == S_LOAD);
    assign bus.done         = (state_q == S_DONE);
    assign bus.err_underrun = err_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_spi_multi_bank_loader.sv
// Directed bench: a 4-channel MSB-first loader, plus a 1-channel LSB-first loader
// that shadows channel 0 of the same stimulus.
module tb_spi_multi_bank_loader;
    localparam int NUM_CH    = 4;
    localparam int MEM_BW    = 18;
    localparam int MEM_DEPTH = 256;
    localparam int DW        = NUM_CH * MEM_BW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_multi_bank_loader_if #(.NUM_CH(NUM_CH), .MEM_BW(MEM_BW), .MEM_DEPTH(MEM_DEPTH)) bus0 ();
    spi_multi_bank_loader_if #(.NUM_CH(1), .MEM_BW(MEM_BW), .MEM_DEPTH(MEM_DEPTH)) bus1 ();

    spi_multi_bank_loader #(.NUM_CH(NUM_CH), .MEM_BW(MEM_BW), .MEM_DEPTH(MEM_DEPTH), .MSB_FIRST(1'b1))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    spi_multi_bank_loader #(.NUM_CH(1), .MEM_BW(MEM_BW), .MEM_DEPTH(MEM_DEPTH), .MSB_FIRST(1'b0))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus1.sos             = bus0.sos;
    assign bus1.eos             = bus0.eos;
    assign bus1.ser_in          = bus0.ser_in[0];
    assign bus1.ch_en           = 1'b1;
    assign bus1.num_valid_lines = bus0.num_valid_lines;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected write data queue and observed write log.
    logic [DW-1:0]     exp_q[$];
    logic [DW-1:0]     obs_data[$];
    logic [NUM_CH-1:0] obs_en[$];
    logic [7:0]        obs_addr[$];
    int                obs_cyc[$];
    logic [MEM_BW-1:0] obs1_data[$];

    always @(negedge clk) begin
        if (bus0.wr_en !== '0) begin
            obs_data.push_back(bus0.wr_data);
            obs_en.push_back(bus0.wr_en);
            obs_addr.push_back(bus0.wr_addr);
            obs_cyc.push_back(cyc);
        end
        if (bus1.wr_en !== '0) obs1_data.push_back(bus1.wr_data);
    end

    int vectors     = 0;
    int miscompares = 0;
    int t_sos       = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int nvl, input logic [NUM_CH-1:0] en);
        bus0.num_valid_lines = 9'(nvl);
        bus0.ch_en           = en;
        bus0.ser_in          = '0;
        bus0.sos             = 1'b1;
        tick();
        bus0.sos = 1'b0;
        t_sos    = cyc;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit eos_last);
        for (int b = 0; b < MEM_BW; b++) begin
            for (int c = 0; c < NUM_CH; c++) bus0.ser_in[c] = w[c*MEM_BW + MEM_BW - 1 - b];
            bus0.eos = eos_last && (b == MEM_BW - 1);
            tick();
        end
        bus0.eos = 1'b0;
        exp_q.push_back(w);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bus0.ser_in = 4'($urandom);
            tick();
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic check_writes(input string tag, input int n, input logic [NUM_CH-1:0] en, input int t0);
        logic [DW-1:0] e;
        chk({tag, " count"}, obs_data.size(), n);
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (i < obs_data.size()) begin
                chk($sformatf("%s addr%0d", tag, i), obs_addr[i], i);
                chk($sformatf("%s en%0d", tag, i), obs_en[i], en);
                chk($sformatf("%s data%0d", tag, i), obs_data[i], e);
                chk($sformatf("%s cyc%0d", tag, i), obs_cyc[i], t0 + MEM_BW * (i + 1));
            end
        end
        obs_data.delete();
        obs_en.delete();
        obs_addr.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d, input logic e);
        chk({tag, " busy"}, bus0.busy, b);
        chk({tag, " done"}, bus0.done, d);
        chk({tag, " err"}, bus0.err_underrun, e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_en"}, bus0.wr_en, 0);
        chk({tag, " wr_addr"}, bus0.wr_addr, 0);
        chk({tag, " wr_data"}, bus0.wr_data, 0);
        chk({tag, " state"}, bus0.dbg_state, 0);
        chk({tag, " lsb wr_data"}, bus1.wr_data, 0);
        chk_status(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus0.sos             = 1'b0;
        bus0.eos             = 1'b0;
        bus0.ser_in          = '0;
        bus0.ch_en           = '0;
        bus0.num_valid_lines = '0;

        // Reset values
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();
        obs_data.delete(); obs_en.delete(); obs_addr.delete(); obs_cyc.delete();

        // Three lines on all channels, writes at T+18/36/54, done one cycle after the last
        start_load(3, 4'hF);
        chk_status("load3 start", 1'b1, 1'b0, 1'b0);
        send_word({18'h1E1E1, 18'h00000, 18'h12345, 18'h3FFFF}, 1'b0);
        send_word({18'h0F0F0, 18'h3FFFF, 18'h0ABCD, 18'h00001}, 1'b0);
        send_word({18'h2D2D2, 18'h15555, 18'h3C3C3, 18'h2AAAA}, 1'b0);
        chk_status("load3 last write", 1'b1, 1'b0, 1'b0);
        tick();
        chk_status("load3 end", 1'b0, 1'b1, 1'b0);
        check_writes("load3", 3, 4'hF, t_sos);

        // Bit order: stream 1,0,...,0 gives 20000 MSB-first, 00001 LSB-first
        obs1_data.delete();
        start_load(1, 4'h1);
        send_word(72'h20000, 1'b0);
        tick();
        check_writes("msb", 1, 4'h1, t_sos);
        chk("lsb count", obs1_data.size(), 1);
        if (obs1_data.size() > 0) chk("lsb data", obs1_data[0], 18'h00001);

        // Channel mask
        start_load(2, 4'b0101);
        send_word(rand_word(), 1'b0);
        send_word(rand_word(), 1'b0);
        tick();
        check_writes("mask", 2, 4'b0101, t_sos);

        // Underrun: eos after 4 words + 5 bits
        start_load(10, 4'hF);
        repeat (4) send_word(rand_word(), 1'b0);
        send_bits(5);
        bus0.eos    = 1'b1;
        bus0.ser_in = 4'($urandom);
        tick();
        bus0.eos = 1'b0;
        chk_status("underrun", 1'b0, 1'b1, 1'b1);
        send_bits(40);
        chk_status("underrun hold", 1'b0, 1'b1, 1'b1);
        check_writes("underrun", 4, 4'hF, t_sos);

        // Restart clears the error; eos on the last bit of a word still writes it
        start_load(3, 4'hF);
        chk_status("restart", 1'b1, 1'b0, 1'b0);
        send_word(rand_word(), 1'b0);
        send_word(rand_word(), 1'b1);
        chk_status("eos on last bit", 1'b0, 1'b1, 1'b1);
        tick();
        check_writes("eos on last bit", 2, 4'hF, t_sos);

        // Full depth and clamped depth
        start_load(256, 4'hF);
        repeat (256) send_word(rand_word(), 1'b0);
        tick();
        chk_status("depth256", 1'b0, 1'b1, 1'b0);
        check_writes("depth256", 256, 4'hF, t_sos);

        start_load(300, 4'hF);
        repeat (256) send_word(rand_word(), 1'b0);
        send_bits(30);
        chk_status("depth300", 1'b0, 1'b1, 1'b0);
        check_writes("depth300", 256, 4'hF, t_sos);

        // Zero lines
        start_load(0, 4'hF);
        chk_status("zero lines", 1'b0, 1'b1, 1'b0);
        send_bits(40);
        check_writes("zero lines", 0, 4'hF, t_sos);

        // Reset mid-word of a 5-line load
        start_load(5, 4'hF);
        send_word(rand_word(), 1'b0);
        send_word(rand_word(), 1'b0);
        send_bits(7);
        reset       = 1'b0;
        bus0.ser_in = 4'($urandom);
        tick();
        reset = 1'b1;
        chk_all_zero("mid reset");
        send_bits(40);
        chk_status("no sos", 1'b0, 1'b0, 1'b0);
        check_writes("pre reset", 2, 4'hF, t_sos);

        start_load(1, 4'hF);
        send_word(rand_word(), 1'b0);
        tick();
        chk_status("fresh", 1'b0, 1'b1, 1'b0);
        check_writes("fresh", 1, 4'hF, t_sos);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
